// File: rtl/sram_mem_ctrl_pkg.sv
// Shared constants and state encoding for the 32-bit-to-16-bit SRAM memory controller.
package sram_mem_ctrl_pkg;
  localparam int WORD_WIDTH      = 32;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int SRAM_ADDR_WIDTH = 18;
  localparam int DATA_MEM_BASE   = 1024;
  localparam int WAIT_CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_t;
endpackage

// File: rtl/sram_wait_counter.sv
// Down-counter timing each SRAM half-access: load on phase entry, decrement, flag zero.
module sram_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);
endmodule

// File: rtl/sram_mem_ctrl.sv
// Splits each 32-bit load/store into two timed 16-bit SRAM accesses (low half, then high half).
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int SRAM_WAIT = 2,
  parameter int BASE_ADDR = DATA_MEM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(SRAM_WAIT - 1);

  ctrl_state_t state_reg, state_next;
  logic [16:0] word_reg;
  logic [31:0] wdata_reg;
  logic        write_reg;
  logic [15:0] low_half_reg;
  logic [31:0] rdata_reg;

  logic        req;
  logic        latch_req;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;
  logic [31:0] addr_off;
  logic        addr_unused;

  assign req         = rd_en | wr_en;
  assign addr_off    = addr - 32'(BASE_ADDR);
  // Byte lane and bits beyond the 17-bit word index are deliberately dropped.
  assign addr_unused = ^{addr_off[31:19], addr_off[1:0]};
  assign rdata       = rdata_reg;

  sram_wait_counter #(
    .WIDTH(WAIT_CNT_WIDTH)
  ) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(WAIT_LOAD),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    latch_req  = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    ready      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready = !req;
        if (req) begin
          latch_req  = 1'b1;
          cnt_load   = 1'b1;
          state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_zero) begin
          cnt_load   = 1'b1;
          state_next = ST_HIGH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          state_next = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        ready      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // SRAM pins are decoded from state so reset silences the bus without a clock edge.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state_reg == ST_LOW) begin
      sram_addr   = {word_reg, 1'b0};
      sram_dq_out = write_reg ? wdata_reg[15:0] : 16'h0000;
      sram_dq_oe  = write_reg;
      sram_we_n   = !write_reg;
    end else if (state_reg == ST_HIGH) begin
      sram_addr   = {word_reg, 1'b1};
      sram_dq_out = write_reg ? wdata_reg[31:16] : 16'h0000;
      sram_dq_oe  = write_reg;
      sram_we_n   = !write_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_reg     <= '0;
      wdata_reg    <= '0;
      write_reg    <= 1'b0;
      low_half_reg <= '0;
      rdata_reg    <= '0;
    end else begin
      if (latch_req) begin
        word_reg  <= addr_off[18:2];
        wdata_reg <= wdata;
        write_reg <= wr_en;
      end
      // Low half is staged so rdata only changes once the whole word is in.
      if ((state_reg == ST_LOW) && cnt_zero && !write_reg) begin
        low_half_reg <= sram_dq_in;
      end
      if ((state_reg == ST_HIGH) && cnt_zero && !write_reg) begin
        rdata_reg <= {sram_dq_in, low_half_reg};
      end
    end
  end
endmodule
